// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized input, mid-bit sampling, LSB first.
// Define UART_RX_FRAME_ERR_EN to add the o_frame_err pulse on a bad stop bit.
module uart_rx #(
    parameter int CLKS_PER_BIT = 219,
    parameter int HALF_BIT     = 109
) (
    input  logic       i_clk25MHz,
    input  logic       i_reset_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_busy
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       o_frame_err
`endif
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START_BIT = 2'd1;
    localparam logic [1:0] RECEIVE   = 2'd2;
    localparam logic [1:0] STOP_BIT  = 2'd3;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT);

    logic          rx_meta_q, rx_s_q, rx_d_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
`ifdef UART_RX_FRAME_ERR_EN
    logic          ferr_q, ferr_d;
`endif

    // Synchronizer and edge-detect delay all reset to the idle line level.
    always_ff @(posedge i_clk25MHz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
            rx_d_q    <= rx_s_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        ferr_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                if (rx_d_q && !rx_s_q) begin
                    state_d = START_BIT;
                end
            end
            START_BIT: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? IDLE : RECEIVE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RECEIVE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP_BIT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP_BIT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
`ifdef UART_RX_FRAME_ERR_EN
                    else begin
                        ferr_d = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk25MHz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            ferr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
`ifdef UART_RX_FRAME_ERR_EN
            ferr_q    <= ferr_d;
`endif
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_busy  = (state_q != IDLE);
`ifdef UART_RX_FRAME_ERR_EN
    assign o_frame_err = ferr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, back-to-back, glitch, bad stop, reset abort, async phase.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 219;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       busy;
`ifdef UART_RX_FRAME_ERR_EN
    logic       ferr;
`endif

    int errors = 0;
    int checks = 0;

    always #20 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(109)) dut (
        .i_clk25MHz (clk),
        .i_reset_n  (rst_n),
        .i_rx       (rx),
        .o_data     (data),
        .o_valid    (valid),
        .o_busy     (busy)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .o_frame_err(ferr)
`endif
    );

    // Monitor: logs every o_valid pulse and flags pulses wider than one cycle.
    logic [7:0] log_mem [0:31];
    int   valid_cnt = 0;
    int   long_cnt = 0;
    logic prev_valid = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    int   ferr_cnt = 0;
    int   ferr_long = 0;
    logic prev_ferr = 1'b0;
`endif

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            log_mem[valid_cnt[4:0]] <= data;
            valid_cnt <= valid_cnt + 1;
            if (prev_valid === 1'b1) long_cnt <= long_cnt + 1;
        end
        prev_valid <= valid;
`ifdef UART_RX_FRAME_ERR_EN
        if (ferr === 1'b1) begin
            ferr_cnt <= ferr_cnt + 1;
            if (prev_ferr === 1'b1) ferr_long <= ferr_long + 1;
        end
        prev_ferr <= ferr;
`endif
    end

    task automatic align(input int ph);
        @(posedge clk);
        #ph;
    endtask

    // Drives one frame; caller must already sit ph ns after a rising edge.
    task automatic send_byte(input logic [7:0] d, input logic stop, input int ph,
                             output logic busy_mid);
        busy_mid = 1'b0;
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #ph;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == 4) begin
                repeat (CPB/2) @(posedge clk);
                #ph;
                busy_mid = busy;
                repeat (CPB - CPB/2) @(posedge clk);
                #ph;
            end else begin
                repeat (CPB) @(posedge clk);
                #ph;
            end
        end
        rx = stop;
        repeat (CPB) @(posedge clk);
        #ph;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef UART_RX_FRAME_ERR_EN
        checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", ferr); end
`endif
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_single;
        int base;
        logic bm;
        base = valid_cnt;
`ifdef UART_RX_FRAME_ERR_EN
        begin
            int fbase;
            fbase = ferr_cnt;
`endif
        align(20);
        send_byte(8'h55, 1'b1, 20, bm);
        repeat (10) @(negedge clk);
        checks++; if (bm !== 1'b1) begin errors++; $display("FAIL single_busy_mid: got %b expected 1", bm); end
        checks++; if (valid_cnt - base !== 1) begin errors++; $display("FAIL single_valid_count: got %0d expected 1", valid_cnt - base); end
        checks++; if (data !== 8'h55) begin errors++; $display("FAIL single_data: got %h expected 55", data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy); end
        checks++; if (long_cnt !== 0) begin errors++; $display("FAIL single_valid_width: got %0d wide pulses expected 0", long_cnt); end
`ifdef UART_RX_FRAME_ERR_EN
            checks++; if (ferr_cnt - fbase !== 0) begin errors++; $display("FAIL single_ferr: got %0d pulses expected 0", ferr_cnt - fbase); end
        end
`endif
    endtask

    task automatic test_back_to_back;
        int base;
        logic bm;
        base = valid_cnt;
        align(20);
        send_byte(8'hA5, 1'b1, 20, bm);
        send_byte(8'h3C, 1'b1, 20, bm);
        repeat (10) @(negedge clk);
        checks++; if (valid_cnt - base !== 2) begin errors++; $display("FAIL b2b_valid_count: got %0d expected 2", valid_cnt - base); end
        checks++; if (log_mem[base[4:0]] !== 8'hA5) begin errors++; $display("FAIL b2b_first: got %h expected a5", log_mem[base[4:0]]); end
        checks++; if (log_mem[5'(base + 1)] !== 8'h3C) begin errors++; $display("FAIL b2b_second: got %h expected 3c", log_mem[5'(base + 1)]); end
        checks++; if (long_cnt !== 0) begin errors++; $display("FAIL b2b_valid_width: got %0d wide pulses expected 0", long_cnt); end
    endtask

    task automatic test_glitch;
        int base;
        base = valid_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_during: got %b expected 1", busy); end
        repeat (30) @(negedge clk);
        rx = 1'b1;
        repeat (68) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_after: got %b expected 0", busy); end
        repeat (3 * CPB) @(negedge clk);
        checks++; if (valid_cnt - base !== 0) begin errors++; $display("FAIL glitch_valid: got %0d expected 0", valid_cnt - base); end
        checks++; if (data !== 8'h3C) begin errors++; $display("FAIL glitch_data: got %h expected 3c", data); end
    endtask

    task automatic test_frame_err;
        int base;
        logic bm;
        base = valid_cnt;
`ifdef UART_RX_FRAME_ERR_EN
        begin
            int fbase;
            fbase = ferr_cnt;
`endif
        align(20);
        send_byte(8'hFF, 1'b0, 20, bm);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checks++; if (valid_cnt - base !== 0) begin errors++; $display("FAIL ferr_valid: got %0d expected 0", valid_cnt - base); end
        checks++; if (data !== 8'h3C) begin errors++; $display("FAIL ferr_data_held: got %h expected 3c", data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy: got %b expected 0", busy); end
`ifdef UART_RX_FRAME_ERR_EN
            checks++; if (ferr_cnt - fbase !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d pulses expected 1", ferr_cnt - fbase); end
            checks++; if (ferr_long !== 0) begin errors++; $display("FAIL ferr_width: got %0d wide pulses expected 0", ferr_long); end
        end
`endif
    endtask

    task automatic test_reset_midframe;
        int base;
        logic bm;
        logic [7:0] d;
        d = 8'h81;
        base = valid_cnt;
        align(20);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #20;
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (CPB) @(posedge clk);
            #20;
        end
        rx = d[4];
        repeat (CPB/2) @(posedge clk);
        #20;
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", data); end
        rst_n = 1'b1;
        repeat (10 * CPB) @(negedge clk);
        checks++; if (valid_cnt - base !== 0) begin errors++; $display("FAIL rstmid_no_valid: got %0d expected 0", valid_cnt - base); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got %b expected 0", busy); end
        align(20);
        send_byte(8'h81, 1'b1, 20, bm);
        repeat (10) @(negedge clk);
        checks++; if (valid_cnt - base !== 1) begin errors++; $display("FAIL rstmid_clean_count: got %0d expected 1", valid_cnt - base); end
        checks++; if (data !== 8'h81) begin errors++; $display("FAIL rstmid_clean_data: got %h expected 81", data); end
    endtask

    task automatic test_async_phase;
        int base;
        int ph;
        logic bm;
        base = valid_cnt;
        ph = int'($urandom_range(1, 39));
        align(ph);
        send_byte(8'h00, 1'b1, ph, bm);
        repeat (10) @(negedge clk);
        checks++; if (valid_cnt - base !== 1) begin errors++; $display("FAIL async_valid_count: got %0d expected 1 (phase %0d)", valid_cnt - base, ph); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL async_data: got %h expected 00 (phase %0d)", data, ph); end
        checks++; if (long_cnt !== 0) begin errors++; $display("FAIL async_valid_width: got %0d wide pulses expected 0", long_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        test_async_phase();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
